// File: rtl/adma_atx_scheduler.sv
// Round-robin transaction scheduler in front of adma_data_mover: one registered descriptor
// on the atx_* port, per-channel and total outstanding limits, sticky per-channel errors.
module adma_atx_scheduler #(
  parameter int DMA_CHN_NUM    = 4,
  parameter int SRC_ADDR_W     = 32,
  parameter int DST_ADDR_W     = 32,
  parameter int MST_ID_W       = 5,
  parameter int ATX_LEN_W      = 8,
  parameter int ATX_NUM_OSTD   = 4,
  parameter int CHN_OSTD_MAX   = 2,
  parameter int ID_BASE        = 0,
  localparam int DMA_CHN_NUM_W = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [DMA_CHN_NUM-1:0]                 req_vld,
  output logic [DMA_CHN_NUM-1:0]                 req_rdy,
  input  logic [DMA_CHN_NUM-1:0][SRC_ADDR_W-1:0] req_araddr,
  input  logic [DMA_CHN_NUM-1:0][ATX_LEN_W-1:0]  req_arlen,
  input  logic [DMA_CHN_NUM-1:0][1:0]            req_arburst,
  input  logic [DMA_CHN_NUM-1:0][DST_ADDR_W-1:0] req_awaddr,
  input  logic [DMA_CHN_NUM-1:0][ATX_LEN_W-1:0]  req_awlen,
  input  logic [DMA_CHN_NUM-1:0][1:0]            req_awburst,
  output logic [DMA_CHN_NUM_W-1:0]               atx_chn_id,
  output logic [MST_ID_W-1:0]                    atx_arid,
  output logic [SRC_ADDR_W-1:0]                  atx_araddr,
  output logic [ATX_LEN_W-1:0]                   atx_arlen,
  output logic [1:0]                             atx_arburst,
  output logic [MST_ID_W-1:0]                    atx_awid,
  output logic [DST_ADDR_W-1:0]                  atx_awaddr,
  output logic [ATX_LEN_W-1:0]                   atx_awlen,
  output logic [1:0]                             atx_awburst,
  output logic                                   atx_vld,
  input  logic                                   atx_rdy,
  output logic [DMA_CHN_NUM-1:0][MST_ID_W-1:0]   atx_id,
  input  logic [DMA_CHN_NUM-1:0]                 atx_done,
  input  logic [DMA_CHN_NUM-1:0]                 atx_src_err,
  input  logic [DMA_CHN_NUM-1:0]                 atx_dst_err,
  input  logic [DMA_CHN_NUM-1:0]                 chn_err_clr,
  output logic [DMA_CHN_NUM-1:0]                 chn_err,
  output logic [DMA_CHN_NUM-1:0]                 chn_idle
);

  localparam int CNT_W   = $clog2(CHN_OSTD_MAX + 1);
  localparam int TOT_MAX = (DMA_CHN_NUM * CHN_OSTD_MAX > ATX_NUM_OSTD) ?
                           DMA_CHN_NUM * CHN_OSTD_MAX : ATX_NUM_OSTD;
  localparam int TOT_W   = $clog2(TOT_MAX + 1);

  logic [CNT_W-1:0]         ostd_cnt_q [DMA_CHN_NUM];
  logic [CNT_W-1:0]         ostd_cnt_d [DMA_CHN_NUM];
  logic [DMA_CHN_NUM-1:0]   err_q, err_d;
  logic [DMA_CHN_NUM_W-1:0] rr_ptr_q, rr_ptr_d;

  logic                     atx_vld_q, atx_vld_d;
  logic [DMA_CHN_NUM_W-1:0] atx_chn_id_q, atx_chn_id_d;
  logic [MST_ID_W-1:0]      atx_arid_q, atx_arid_d;
  logic [SRC_ADDR_W-1:0]    atx_araddr_q, atx_araddr_d;
  logic [ATX_LEN_W-1:0]     atx_arlen_q, atx_arlen_d;
  logic [1:0]               atx_arburst_q, atx_arburst_d;
  logic [MST_ID_W-1:0]      atx_awid_q, atx_awid_d;
  logic [DST_ADDR_W-1:0]    atx_awaddr_q, atx_awaddr_d;
  logic [ATX_LEN_W-1:0]     atx_awlen_q, atx_awlen_d;
  logic [1:0]               atx_awburst_q, atx_awburst_d;

  logic [TOT_W-1:0]         total;
  logic                     total_ok;
  logic                     load;
  logic                     grant;
  logic                     win_found;
  logic [DMA_CHN_NUM_W-1:0] win_idx;
  logic [DMA_CHN_NUM-1:0]   elig;

  assign load     = ~atx_vld_q | atx_rdy;
  assign total_ok = (total < TOT_W'(ATX_NUM_OSTD));
  // Gated by rst_n so no request is acknowledged while the block is held in reset.
  assign grant    = rst_n & load & win_found;

  always_comb begin
    total = '0;
    for (int c = 0; c < DMA_CHN_NUM; c++) begin
      total = total + TOT_W'(ostd_cnt_q[c]);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DMA_CHN_NUM; gi++) begin : g_chn
      assign elig[gi]     = req_vld[gi] & ~err_q[gi] &
                            (ostd_cnt_q[gi] < CNT_W'(CHN_OSTD_MAX)) & total_ok;
      assign req_rdy[gi]  = grant & (win_idx == DMA_CHN_NUM_W'(gi));
      assign atx_id[gi]   = MST_ID_W'(ID_BASE + gi);
      assign chn_idle[gi] = (ostd_cnt_q[gi] == '0) &
                            ~(atx_vld_q & (atx_chn_id_q == DMA_CHN_NUM_W'(gi)));
    end
  endgenerate

  // First eligible channel at or after the round-robin pointer, wrapping modulo N.
  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < DMA_CHN_NUM; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= DMA_CHN_NUM) begin
        cand = cand - DMA_CHN_NUM;
      end
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_idx   = DMA_CHN_NUM_W'(cand);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      rr_ptr_d = (win_idx == DMA_CHN_NUM_W'(DMA_CHN_NUM - 1)) ? '0 :
                 win_idx + DMA_CHN_NUM_W'(1);
    end
  end

  // A grant and a completion in the same cycle cancel; completions never underflow.
  always_comb begin
    for (int c = 0; c < DMA_CHN_NUM; c++) begin
      ostd_cnt_d[c] = ostd_cnt_q[c];
      if (req_rdy[c] && !atx_done[c]) begin
        ostd_cnt_d[c] = ostd_cnt_q[c] + CNT_W'(1);
      end else if (!req_rdy[c] && atx_done[c] && (ostd_cnt_q[c] != '0)) begin
        ostd_cnt_d[c] = ostd_cnt_q[c] - CNT_W'(1);
      end
    end
    err_d = (err_q & ~chn_err_clr) | atx_src_err | atx_dst_err;
  end

  always_comb begin
    atx_vld_d     = atx_vld_q;
    atx_chn_id_d  = atx_chn_id_q;
    atx_arid_d    = atx_arid_q;
    atx_araddr_d  = atx_araddr_q;
    atx_arlen_d   = atx_arlen_q;
    atx_arburst_d = atx_arburst_q;
    atx_awid_d    = atx_awid_q;
    atx_awaddr_d  = atx_awaddr_q;
    atx_awlen_d   = atx_awlen_q;
    atx_awburst_d = atx_awburst_q;
    if (load) begin
      atx_vld_d = grant;
      if (grant) begin
        atx_chn_id_d  = win_idx;
        atx_arid_d    = MST_ID_W'(ID_BASE) + MST_ID_W'(win_idx);
        atx_awid_d    = MST_ID_W'(ID_BASE) + MST_ID_W'(win_idx);
        atx_araddr_d  = req_araddr[win_idx];
        atx_arlen_d   = req_arlen[win_idx];
        atx_arburst_d = req_arburst[win_idx];
        atx_awaddr_d  = req_awaddr[win_idx];
        atx_awlen_d   = req_awlen[win_idx];
        atx_awburst_d = req_awburst[win_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < DMA_CHN_NUM; c++) begin
        ostd_cnt_q[c] <= '0;
      end
      err_q         <= '0;
      rr_ptr_q      <= '0;
      atx_vld_q     <= 1'b0;
      atx_chn_id_q  <= '0;
      atx_arid_q    <= '0;
      atx_araddr_q  <= '0;
      atx_arlen_q   <= '0;
      atx_arburst_q <= '0;
      atx_awid_q    <= '0;
      atx_awaddr_q  <= '0;
      atx_awlen_q   <= '0;
      atx_awburst_q <= '0;
    end else begin
      for (int c = 0; c < DMA_CHN_NUM; c++) begin
        ostd_cnt_q[c] <= ostd_cnt_d[c];
      end
      err_q         <= err_d;
      rr_ptr_q      <= rr_ptr_d;
      atx_vld_q     <= atx_vld_d;
      atx_chn_id_q  <= atx_chn_id_d;
      atx_arid_q    <= atx_arid_d;
      atx_araddr_q  <= atx_araddr_d;
      atx_arlen_q   <= atx_arlen_d;
      atx_arburst_q <= atx_arburst_d;
      atx_awid_q    <= atx_awid_d;
      atx_awaddr_q  <= atx_awaddr_d;
      atx_awlen_q   <= atx_awlen_d;
      atx_awburst_q <= atx_awburst_d;
    end
  end

  assign atx_vld     = atx_vld_q;
  assign atx_chn_id  = atx_chn_id_q;
  assign atx_arid    = atx_arid_q;
  assign atx_araddr  = atx_araddr_q;
  assign atx_arlen   = atx_arlen_q;
  assign atx_arburst = atx_arburst_q;
  assign atx_awid    = atx_awid_q;
  assign atx_awaddr  = atx_awaddr_q;
  assign atx_awlen   = atx_awlen_q;
  assign atx_awburst = atx_awburst_q;
  assign chn_err     = err_q;

endmodule

// File: tb/tb_adma_atx_scheduler.sv
// Randomized plus directed bench for adma_atx_scheduler against a per-channel
// counting model of the arbitration, outstanding limits and error rules.
module tb_adma_atx_scheduler;

  localparam int N       = 4;
  localparam int OSTD    = 4;
  localparam int CHN_MAX = 2;
  localparam int ID_BASE = 0;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N-1:0]        req_vld;
  logic [N-1:0]        req_rdy;
  logic [N-1:0][31:0]  req_araddr, req_awaddr;
  logic [N-1:0][7:0]   req_arlen, req_awlen;
  logic [N-1:0][1:0]   req_arburst, req_awburst;
  logic [1:0]          atx_chn_id;
  logic [4:0]          atx_arid, atx_awid;
  logic [31:0]         atx_araddr, atx_awaddr;
  logic [7:0]          atx_arlen, atx_awlen;
  logic [1:0]          atx_arburst, atx_awburst;
  logic                atx_vld;
  logic                atx_rdy;
  logic [N-1:0][4:0]   atx_id;
  logic [N-1:0]        atx_done, atx_src_err, atx_dst_err, chn_err_clr;
  logic [N-1:0]        chn_err, chn_idle;

  adma_atx_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy),
    .req_araddr(req_araddr), .req_arlen(req_arlen), .req_arburst(req_arburst),
    .req_awaddr(req_awaddr), .req_awlen(req_awlen), .req_awburst(req_awburst),
    .atx_chn_id(atx_chn_id), .atx_arid(atx_arid), .atx_araddr(atx_araddr),
    .atx_arlen(atx_arlen), .atx_arburst(atx_arburst), .atx_awid(atx_awid),
    .atx_awaddr(atx_awaddr), .atx_awlen(atx_awlen), .atx_awburst(atx_awburst),
    .atx_vld(atx_vld), .atx_rdy(atx_rdy), .atx_id(atx_id),
    .atx_done(atx_done), .atx_src_err(atx_src_err), .atx_dst_err(atx_dst_err),
    .chn_err_clr(chn_err_clr), .chn_err(chn_err), .chn_idle(chn_idle)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int          m_cnt [N];
  bit          m_err [N];
  int          m_rr;
  bit          m_vld;
  int          m_chn;
  logic [31:0] m_araddr, m_awaddr;
  logic [7:0]  m_arlen, m_awlen;
  logic [1:0]  m_arburst, m_awburst;
  logic [N-1:0] last_rdy;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_cnt[c] = 0;
      m_err[c] = 0;
    end
    m_rr = 0;
    m_vld = 0;
    m_chn = 0;
  endtask

  task automatic rand_fields();
    for (int c = 0; c < N; c++) begin
      req_araddr[c]  = $urandom;
      req_awaddr[c]  = $urandom;
      req_arlen[c]   = 8'($urandom);
      req_awlen[c]   = 8'($urandom);
      req_arburst[c] = 2'($urandom);
      req_awburst[c] = 2'($urandom);
    end
  endtask

  function automatic int model_winner();
    int tot;
    tot = 0;
    for (int c = 0; c < N; c++) tot += m_cnt[c];
    if (m_vld && !atx_rdy) return -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_rr + k) % N;
      if (req_vld[c] && !m_err[c] && m_cnt[c] < CHN_MAX && tot < OSTD) return c;
    end
    return -1;
  endfunction

  // Called just after a falling edge with inputs set; checks, advances the model,
  // then returns at the next falling edge with pulse inputs cleared.
  task automatic step();
    int w;
    bit load;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_idle;
    logic [N-1:0] exp_err;
    #1;
    w = model_winner();
    load = !m_vld || atx_rdy;
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    last_rdy = req_rdy;
    for (int c = 0; c < N; c++) begin
      exp_idle[c] = (m_cnt[c] == 0) && !(m_vld && m_chn == c);
      exp_err[c]  = m_err[c];
    end
    chk("req_rdy", req_rdy, exp_rdy);
    chk("atx_vld", atx_vld, m_vld);
    chk("chn_err", chn_err, exp_err);
    chk("chn_idle", chn_idle, exp_idle);
    if (m_vld) begin
      chk("atx_chn_id", atx_chn_id, m_chn);
      chk("atx_arid", atx_arid, ID_BASE + m_chn);
      chk("atx_awid", atx_awid, ID_BASE + m_chn);
      chk("atx_araddr", atx_araddr, m_araddr);
      chk("atx_arlen", atx_arlen, m_arlen);
      chk("atx_arburst", atx_arburst, m_arburst);
      chk("atx_awaddr", atx_awaddr, m_awaddr);
      chk("atx_awlen", atx_awlen, m_awlen);
      chk("atx_awburst", atx_awburst, m_awburst);
    end
    for (int c = 0; c < N; c++) begin
      if (w == c && atx_done[c]) begin
      end else if (w == c) begin
        m_cnt[c]++;
      end else if (atx_done[c] && m_cnt[c] > 0) begin
        m_cnt[c]--;
      end
      if (atx_src_err[c] || atx_dst_err[c]) m_err[c] = 1;
      else if (chn_err_clr[c]) m_err[c] = 0;
    end
    if (load) begin
      if (w >= 0) begin
        m_vld     = 1;
        m_chn     = w;
        m_araddr  = req_araddr[w];
        m_arlen   = req_arlen[w];
        m_arburst = req_arburst[w];
        m_awaddr  = req_awaddr[w];
        m_awlen   = req_awlen[w];
        m_awburst = req_awburst[w];
      end else begin
        m_vld = 0;
      end
    end
    if (w >= 0) m_rr = (w + 1) % N;
    @(posedge clk);
    @(negedge clk);
    atx_done    = '0;
    atx_src_err = '0;
    atx_dst_err = '0;
    chn_err_clr = '0;
    rand_fields();
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) begin
      req_vld     = '0;
      atx_rdy     = 1'b1;
      atx_done    = '1;
      chn_err_clr = '1;
      step();
    end
  endtask

  initial begin
    logic [31:0] t3_araddr;
    logic [7:0]  t3_awlen;
    int          pulses;

    rst_n = 1'b0;
    req_vld = '1;
    atx_rdy = 1'b1;
    atx_done = '0;
    atx_src_err = '0;
    atx_dst_err = '0;
    chn_err_clr = '0;
    rand_fields();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_atx_vld", atx_vld, 0);
    chk("rst_req_rdy", req_rdy, 0);
    chk("rst_chn_idle", chn_idle, 4'hF);
    chk("rst_chn_err", chn_err, 0);
    chk("rst_fields", {atx_chn_id, atx_arid, atx_awid, atx_arlen, atx_awlen}, 0);
    chk("rst_addr", {atx_araddr, atx_awaddr}, 0);
    for (int c = 0; c < N; c++) chk("atx_id", atx_id[c], ID_BASE + c);
    rst_n = 1'b1;

    // Round-robin fill up to the total outstanding limit
    for (int i = 0; i < N; i++) begin
      req_vld = '1;
      atx_rdy = 1'b1;
      step();
      chk("t1_grant", last_rdy, 4'b0001 << i);
    end
    req_vld = '1;
    step();
    chk("t1_stall_rdy", last_rdy, 0);
    chk("t1_stall_vld", atx_vld, 0);

    // Completion on channel 2 frees the only slot
    req_vld = 4'b0100;
    atx_done = 4'b0100;
    step();
    chk("t2_no_grant", last_rdy, 0);
    req_vld = 4'b0100;
    step();
    chk("t2_grant", last_rdy, 4'b0100);
    chk("t2_arid", atx_arid, ID_BASE + 2);
    chk("t2_awid", atx_awid, ID_BASE + 2);
    drain();

    // Back-pressure: one grant, stable descriptor
    req_vld = 4'b0010;
    atx_rdy = 1'b0;
    t3_araddr = req_araddr[1];
    t3_awlen = req_awlen[1];
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      req_vld = 4'b0010;
      atx_rdy = 1'b0;
      step();
      pulses += int'(last_rdy[1]);
      chk("t3_vld", atx_vld, 1);
      chk("t3_araddr", atx_araddr, t3_araddr);
      chk("t3_awlen", atx_awlen, t3_awlen);
      chk("t3_idle1", chn_idle[1], 0);
    end
    chk("t3_pulses", pulses, 1);
    req_vld = '0;
    atx_rdy = 1'b1;
    step();
    drain();

    // Error and clear in the same cycle: the error wins
    req_vld = '0;
    atx_dst_err = 4'b1000;
    chn_err_clr = 4'b1000;
    step();
    for (int i = 0; i < 3; i++) begin
      req_vld = 4'b1000;
      atx_rdy = 1'b1;
      step();
      chk("t4_blocked", last_rdy, 0);
      chk("t4_err", chn_err[3], 1);
    end
    req_vld = 4'b1000;
    chn_err_clr = 4'b1000;
    step();
    chk("t4_clr_cycle", last_rdy, 0);
    req_vld = 4'b1000;
    step();
    chk("t4_resume", last_rdy, 4'b1000);
    drain();

    // Counter corner cases on channel 0
    req_vld = 4'b0001;
    step();
    req_vld = 4'b0001;
    atx_done = 4'b0001;
    step();
    chk("t5_grant_done", last_rdy, 4'b0001);
    req_vld = '0;
    step();
    chk("t5_cnt_kept", chn_idle[0], 0);
    atx_done = 4'b0001;
    step();
    chk("t5_cnt_zero", chn_idle[0], 1);
    atx_done = 4'b0001;
    step();
    chk("t5_sat_idle", chn_idle[0], 1);
    for (int i = 0; i < 3; i++) begin
      req_vld = 4'b0001;
      step();
      chk("t5_limit", last_rdy, (i < 2) ? 4'b0001 : 4'b0000);
    end
    drain();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      req_vld = 4'($urandom);
      atx_rdy = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < N; c++) begin
        atx_done[c]    = ($urandom_range(0, 2) == 0);
        atx_src_err[c] = ($urandom_range(0, 39) == 0);
        atx_dst_err[c] = ($urandom_range(0, 39) == 0);
        chn_err_clr[c] = ($urandom_range(0, 5) == 0);
      end
      step();
    end

    // Asynchronous reset in the middle of a transfer
    drain();
    req_vld = '1;
    atx_rdy = 1'b0;
    atx_src_err = 4'b0100;
    step();
    chk("t6_pre_vld", atx_vld, 1);
    chk("t6_pre_err", chn_err[2], 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_vld", atx_vld, 0);
    chk("t6_async_idle", chn_idle, 4'hF);
    chk("t6_async_err", chn_err, 0);
    chk("t6_async_rdy", req_rdy, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_vld = '1;
      atx_rdy = 1'b1;
      step();
      chk("t6_restart", last_rdy, 4'b0001 << i);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
